stack_unit: RTL and testbench
=============================

# stack_unit

Parametrised operand stack for the multicycle stack-machine datapath. It replaces the fixed push/pop/tos stack with a configurable-width, configurable-depth LIFO. It adds DUP, SWAP, replace-top and binary-reduce commands, and exposes the two top entries so the A/B operand registers load in parallel. It also provides full/empty status, an occupancy count and overflow/underflow error reporting to the controller.

## Interface
Parameters:
- WIDTH, 8: data width of each entry
- DEPTH, 16: number of entries; legal range DEPTH >= 2
- CW, $clog2(DEPTH+1): count width (derived, do not override)

Ports:
- clk  input  1  clock; all state changes on rising edge
- rst  input  1  synchronous active-low reset; reset occurs when rst == 0 at a rising edge
- cmd_valid  input  1  command strobe; one command per asserted cycle
- cmd  input  3  command: 0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 REPL1, 6 REPL2, 7 CLEAR
- data_in  input  WIDTH  operand for PUSH/REPL1/REPL2
- err_clr  input  1  clears sticky error flags (only with STACK_ERR_STICKY_EN)
- tos  output  WIDTH  top entry; 0 when empty
- nos  output  WIDTH  second entry; 0 when count < 2
- count  output  CW  occupancy, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- ovf_err  output  1  overflow error
- unf_err  output  1  underflow error

## Operation
- Storage: register array of DEPTH entries, index 0 = bottom. Entry c-1 is top, where c = count. The array is not reset; tos/nos are gated to 0 when invalid.
- Commands are effective only when cmd_valid = 1. With cmd_valid = 0 or cmd = NOP, nothing changes.
- PUSH: requires c < DEPTH. Writes data_in to entry c; count becomes c+1.
- POP: requires c >= 1. Count becomes c-1; entry contents are untouched.
- DUP: requires 1 <= c < DEPTH. Copies entry c-1 to entry c; count becomes c+1.
- SWAP: requires c >= 2. Exchanges entries c-1 and c-2; count is unchanged.
- REPL1 (pop one, push result): requires c >= 1. Writes data_in to entry c-1; count is unchanged.
- REPL2 (pop two, push result; used for ALU binary ops): requires c >= 2. Writes data_in to entry c-2; count becomes c-1.
- CLEAR: count becomes 0; always legal; no error.
- Illegal command (precondition false): no change to array or count.
  - PUSH or DUP while full: flags overflow.
  - Any other command with insufficient entries: flags underflow.
- Error reporting:
  - Sticky mode: the error flag sets and holds until cleared by err_clr or reset.
  - Pulse mode: the error flag is high for exactly one cycle.
- tos, nos, empty and full are combinational from count and the array, so they always reflect current registered state.

## Timing
- Reset (rst = 0 at an edge): count = 0, empty = 1, full = 0, tos = 0, nos = 0, ovf_err = 0, unf_err = 0. Reset overrides any command issued in the same cycle.
- Latency: a command sampled at edge n is visible on tos/nos/count/flags immediately after edge n. Back-to-back commands are allowed every cycle; there is no busy state.
- Error flags update at the same edge as the offending command.
- Sticky mode, err_clr and a new error in the same cycle: the new error wins (flag = 1).
- Boundaries:
  - PUSH at c = DEPTH-1 succeeds and full rises.
  - POP at c = 1 succeeds and empty rises.
  - DUP at c = DEPTH-1 succeeds.
  - REPL2 at c = 2 leaves c = 1.
  - count never wraps.

## Configuration
- STACK_ERR_STICKY_EN defined: ovf_err/unf_err are sticky until err_clr = 1 or reset.
- STACK_ERR_STICKY_EN undefined: ovf_err/unf_err are one-cycle pulses in the cycle after the offending command. err_clr is ignored but the port remains.

## Test plan
- Reset then PUSH 0x11, 0x22, 0x33 -> count = 3, tos = 0x33, nos = 0x22; then POP -> tos = 0x22, nos = 0x11, count = 2.
- DEPTH = 4: PUSH 1,2,3,4 -> full = 1; PUSH 5 -> ovf_err = 1, count = 4, tos = 4; DUP -> ovf_err again, state unchanged.
- Empty stack: POP -> unf_err = 1, count = 0, tos = 0. PUSH 7, then SWAP -> unf_err = 1, tos = 7, count = 1.
- PUSH 5, PUSH 9, SWAP -> tos = 5, nos = 9. REPL2 with data_in = 0x0E -> count = 1, tos = 0x0E, nos = 0.
- PUSH 0xA5, DUP -> count = 2, tos = nos = 0xA5. REPL1 with data_in = 0x3C -> tos = 0x3C, nos = 0xA5. CLEAR -> empty = 1, no error.
- Sticky build: POP when empty -> unf_err stays 1 for 5 idle cycles. err_clr -> unf_err = 0. rst = 0 while count = 3 with PUSH asserted -> count = 0 next cycle.
- Pulse build: same POP when empty -> unf_err high for exactly one cycle.

Source files
------------

// File: rtl/stack_unit.sv
// stack_unit: parametrised LIFO operand stack with PUSH/POP/DUP/SWAP/REPL1/REPL2/CLEAR.
// Ports:
//   clk, rst (sync active-low), cmd_valid, cmd[2:0], data_in, err_clr
//   -> tos, nos, count, empty, full, ovf_err, unf_err.
// Build option: STACK_ERR_STICKY_EN selects sticky error flags (cleared by err_clr);
//   when it is undefined, the error flags are one-cycle pulses.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd,
    input  logic [WIDTH-1:0] data_in,
    input  logic             err_clr,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] nos,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf_err,
    output logic             unf_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [2:0] C_NOP   = 3'd0;
    localparam logic [2:0] C_PUSH  = 3'd1;
    localparam logic [2:0] C_POP   = 3'd2;
    localparam logic [2:0] C_DUP   = 3'd3;
    localparam logic [2:0] C_SWAP  = 3'd4;
    localparam logic [2:0] C_REPL1 = 3'd5;
    localparam logic [2:0] C_REPL2 = 3'd6;
    localparam logic [2:0] C_CLEAR = 3'd7;

    localparam logic [CW-1:0] N_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] N_ONE  = CW'(1);
    localparam logic [CW-1:0] N_TWO  = CW'(2);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic             ovf_q;
    logic             unf_q;

    // i0: next free slot, i1: top, i2: second from top
    logic [AW-1:0] i0;
    logic [AW-1:0] i1;
    logic [AW-1:0] i2;

    assign i0 = AW'(cnt);
    assign i1 = AW'(cnt - N_ONE);
    assign i2 = AW'(cnt - N_TWO);

    logic             has1;
    logic             has2;
    logic             is_full;

    assign has1    = (cnt != '0);
    assign has2    = (cnt >= N_TWO);
    assign is_full = (cnt == N_FULL);

    // Two write ports so SWAP can exchange both entries in one cycle
    logic             we0;
    logic [AW-1:0]    wa0;
    logic [WIDTH-1:0] wd0;
    logic             we1;
    logic [AW-1:0]    wa1;
    logic [WIDTH-1:0] wd1;
    logic [CW-1:0]    cnt_nxt;
    logic             ovf_now;
    logic             unf_now;

    always_comb begin
        we0     = 1'b0;
        wa0     = i0;
        wd0     = data_in;
        we1     = 1'b0;
        wa1     = i2;
        wd1     = mem[i1];
        cnt_nxt = cnt;
        ovf_now = 1'b0;
        unf_now = 1'b0;
        if (cmd_valid) begin
            unique case (cmd)
                C_NOP: begin
                end
                C_PUSH: begin
                    if (is_full) begin
                        ovf_now = 1'b1;
                    end else begin
                        we0     = 1'b1;
                        wa0     = i0;
                        wd0     = data_in;
                        cnt_nxt = cnt + N_ONE;
                    end
                end
                C_POP: begin
                    if (!has1) unf_now = 1'b1;
                    else       cnt_nxt = cnt - N_ONE;
                end
                C_DUP: begin
                    if (is_full) begin
                        ovf_now = 1'b1;
                    end else if (!has1) begin
                        unf_now = 1'b1;
                    end else begin
                        we0     = 1'b1;
                        wa0     = i0;
                        wd0     = mem[i1];
                        cnt_nxt = cnt + N_ONE;
                    end
                end
                C_SWAP: begin
                    if (!has2) begin
                        unf_now = 1'b1;
                    end else begin
                        we0 = 1'b1;
                        wa0 = i1;
                        wd0 = mem[i2];
                        we1 = 1'b1;
                        wa1 = i2;
                        wd1 = mem[i1];
                    end
                end
                C_REPL1: begin
                    if (!has1) begin
                        unf_now = 1'b1;
                    end else begin
                        we0 = 1'b1;
                        wa0 = i1;
                        wd0 = data_in;
                    end
                end
                C_REPL2: begin
                    if (!has2) begin
                        unf_now = 1'b1;
                    end else begin
                        we0     = 1'b1;
                        wa0     = i2;
                        wd0     = data_in;
                        cnt_nxt = cnt - N_ONE;
                    end
                end
                C_CLEAR: begin
                    cnt_nxt = '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Array is not reset; writes are suppressed while reset is asserted
    always_ff @(posedge clk) begin
        if (rst && we0) mem[wa0] <= wd0;
        if (rst && we1) mem[wa1] <= wd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            cnt <= cnt_nxt;
`ifdef STACK_ERR_STICKY_EN
            // A new error outranks a simultaneous clear
            ovf_q <= ovf_now | (ovf_q & ~err_clr);
            unf_q <= unf_now | (unf_q & ~err_clr);
`else
            ovf_q <= ovf_now;
            unf_q <= unf_now;
`endif
        end
    end

`ifndef STACK_ERR_STICKY_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    assign tos     = has1 ? mem[i1] : '0;
    assign nos     = has2 ? mem[i2] : '0;
    assign count   = cnt;
    assign empty   = !has1;
    assign full    = is_full;
    assign ovf_err = ovf_q;
    assign unf_err = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed self-checking bench for stack_unit (DEPTH=4, WIDTH=8).
// Ports exercised: all; expectations follow the build's error-flag mode.
module tb_stack_unit;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

`ifdef STACK_ERR_STICKY_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [W-1:0]  data_in = '0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  tos;
    logic [W-1:0]  nos;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          ovf_err;
    logic          unf_err;

    int checks = 0;
    int failures = 0;

    stack_unit #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
        .data_in(data_in), .err_clr(err_clr), .tos(tos), .nos(nos),
        .count(count), .empty(empty), .full(full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3;
    localparam logic [2:0] SWAP = 3'd4, REPL1 = 3'd5, REPL2 = 3'd6, CLR = 3'd7;

    // Apply one command across a single rising edge, sample 1 ns later
    task automatic step(input logic v, input logic [2:0] c,
                        input logic [W-1:0] d, input logic ec, input logic r);
        @(negedge clk);
        cmd_valid = v;
        cmd       = c;
        data_in   = d;
        err_clr   = ec;
        rst       = r;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        rst       = 1'b1;
    endtask

    task automatic op(input logic [2:0] c, input logic [W-1:0] d);
        step(1'b1, c, d, 1'b0, 1'b1);
    endtask

    task automatic idle();
        step(1'b0, NOP, '0, 1'b0, 1'b1);
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with a PUSH pending: reset must win
        step(1'b1, PUSH, 8'h55, 1'b0, 1'b0);
        step(1'b1, PUSH, 8'h55, 1'b0, 1'b0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_tos", int'(tos), 0);
        chk("rst_nos", int'(nos), 0);
        chk("rst_ovf", int'(ovf_err), 0);
        chk("rst_unf", int'(unf_err), 0);

        // basic push/pop
        op(PUSH, 8'h11);
        op(PUSH, 8'h22);
        op(PUSH, 8'h33);
        chk("p3_count", int'(count), 3);
        chk("p3_tos", int'(tos), 'h33);
        chk("p3_nos", int'(nos), 'h22);
        op(POP, 0);
        chk("pop_tos", int'(tos), 'h22);
        chk("pop_nos", int'(nos), 'h11);
        chk("pop_count", int'(count), 2);
        idle();
        chk("idle_count", int'(count), 2);
        op(CLR, 0);
        chk("clr_empty", int'(empty), 1);

        // overflow
        op(PUSH, 8'h01);
        op(PUSH, 8'h02);
        op(PUSH, 8'h03);
        chk("pre_full", int'(full), 0);
        op(PUSH, 8'h04);
        chk("full_set", int'(full), 1);
        chk("full_ovf0", int'(ovf_err), 0);
        op(PUSH, 8'h05);
        chk("ovf_push", int'(ovf_err), 1);
        chk("ovf_count", int'(count), 4);
        chk("ovf_tos", int'(tos), 4);
        op(DUP, 0);
        chk("ovf_dup", int'(ovf_err), 1);
        chk("dup_count", int'(count), 4);
        chk("dup_tos", int'(tos), 4);
        chk("dup_nos", int'(nos), 3);
        idle();
        chk("ovf_after", int'(ovf_err), STICKY ? 1 : 0);
        step(1'b1, CLR, '0, 1'b1, 1'b1);
        chk("ovf_clr", int'(ovf_err), 0);
        chk("clr2_count", int'(count), 0);

        // underflow
        op(POP, 0);
        chk("unf_pop", int'(unf_err), 1);
        chk("unf_count", int'(count), 0);
        chk("unf_tos", int'(tos), 0);
        op(PUSH, 8'h07);
        if (!STICKY) chk("unf_pulse", int'(unf_err), 0);
        op(SWAP, 0);
        chk("unf_swap", int'(unf_err), 1);
        chk("swap1_tos", int'(tos), 7);
        chk("swap1_count", int'(count), 1);
        op(REPL2, 8'h99);
        chk("unf_repl2", int'(unf_err), 1);
        chk("repl2_1_tos", int'(tos), 7);
        op(POP, 0);
        chk("pop1_empty", int'(empty), 1);
        step(1'b1, REPL1, 8'h42, 1'b1, 1'b1);
        chk("unf_repl1", int'(unf_err), 1);
        op(DUP, 0);
        chk("unf_dup", int'(unf_err), 1);
        chk("dup0_count", int'(count), 0);
        step(1'b0, NOP, '0, 1'b1, 1'b1);
        chk("unf_clr", int'(unf_err), 0);

        // swap and reduce
        op(PUSH, 8'h05);
        op(PUSH, 8'h09);
        op(SWAP, 0);
        chk("swap_tos", int'(tos), 5);
        chk("swap_nos", int'(nos), 9);
        chk("swap_unf", int'(unf_err), 0);
        op(REPL2, 8'h0E);
        chk("r2_count", int'(count), 1);
        chk("r2_tos", int'(tos), 'h0E);
        chk("r2_nos", int'(nos), 0);
        op(CLR, 0);

        // dup / repl1 / clear
        op(PUSH, 8'hA5);
        op(DUP, 0);
        chk("dup2_count", int'(count), 2);
        chk("dup2_tos", int'(tos), 'hA5);
        chk("dup2_nos", int'(nos), 'hA5);
        op(REPL1, 8'h3C);
        chk("r1_tos", int'(tos), 'h3C);
        chk("r1_nos", int'(nos), 'hA5);
        chk("r1_count", int'(count), 2);
        op(CLR, 0);
        chk("clr3_empty", int'(empty), 1);
        chk("clr3_ovf", int'(ovf_err), 0);
        chk("clr3_unf", int'(unf_err), 0);

        // DUP at DEPTH-1 succeeds
        op(PUSH, 8'h61);
        op(PUSH, 8'h62);
        op(PUSH, 8'h63);
        op(DUP, 0);
        chk("dupb_count", int'(count), 4);
        chk("dupb_full", int'(full), 1);
        chk("dupb_tos", int'(tos), 'h63);
        chk("dupb_nos", int'(nos), 'h63);
        chk("dupb_ovf", int'(ovf_err), 0);
        op(CLR, 0);

        // error hold over idle cycles
        op(POP, 0);
        chk("hold_set", int'(unf_err), 1);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("hold_idle", int'(unf_err), STICKY ? 1 : 0);
        end
        step(1'b0, NOP, '0, 1'b1, 1'b1);
        chk("hold_clr", int'(unf_err), 0);
        // clear and new error together: error wins
        step(1'b1, POP, '0, 1'b1, 1'b1);
        chk("clr_vs_err", int'(unf_err), 1);
        step(1'b0, NOP, '0, 1'b1, 1'b1);
        chk("clr_again", int'(unf_err), 0);

        // reset with count 3 and PUSH asserted
        op(PUSH, 8'h01);
        op(PUSH, 8'h02);
        op(PUSH, 8'h03);
        chk("pre_rst", int'(count), 3);
        step(1'b1, PUSH, 8'h44, 1'b0, 1'b0);
        chk("rst2_count", int'(count), 0);
        chk("rst2_tos", int'(tos), 0);
        chk("rst2_empty", int'(empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
